// File: rtl/enemy_formation_drawer.sv
// Walks a grid formation of enemies and streams the shared sprite ROM into the VGA plot port.
// Supports animation frames, transparent pixels, screen clipping and an erase pass.
module enemy_formation_drawer #(
  parameter int SPRITE_W = 16,
  parameter int SPRITE_H = 8,
  parameter int FRAMES = 2,
  parameter int NUM_ENEMIES = 8,
  parameter int COLS = 4,
  parameter int STEP_X = 20,
  parameter int STEP_Y = 12,
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240,
  parameter logic [2:0] TRANSPARENT = 3'b000,
  parameter logic [2:0] BG_COLOUR = 3'b000,
  parameter int ROM_AW = $clog2(FRAMES * SPRITE_W * SPRITE_H),
  parameter int FRAME_W = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   start,
  input  logic                   erase,
  input  logic [FRAME_W-1:0]     frame,
  input  logic [8:0]             form_x,
  input  logic [7:0]             form_y,
  input  logic [NUM_ENEMIES-1:0] alive,
  output logic [ROM_AW-1:0]      rom_address,
  input  logic [2:0]             rom_q,
  output logic [8:0]             final_x_pos,
  output logic [7:0]             final_y_pos,
  output logic [2:0]             colour,
  output logic                   plot,
  output logic                   busy,
  output logic                   done
);

  // state  | meaning
  // IDLE   | waiting for start
  // SELECT | test alive bit of enemy idx, skip dead ones
  // DRAW   | one ROM address per cycle for enemy idx
  // DRAIN  | flush the final plot stage
  // DONE   | one-cycle done pulse

  localparam int IW  = (NUM_ENEMIES > 1) ? $clog2(NUM_ENEMIES) : 1;
  localparam int CXW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int CYW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

  typedef enum logic [2:0] {IDLE, SELECT, DRAW, DRAIN, DONE} state_t;

  state_t                 state;
  logic [IW-1:0]          idx;
  logic [CXW-1:0]         cx;
  logic [CYW-1:0]         cy;
  logic                   erase_r;
  logic [FRAME_W-1:0]     frame_r;
  logic [8:0]             form_x_r;
  logic [7:0]             form_y_r;
  logic [NUM_ENEMIES-1:0] alive_r;

  logic                   p_valid;
  logic                   p_erase;
  logic [9:0]             p_x;
  logic [9:0]             p_y;
  logic [8:0]             last_x;
  logic [7:0]             last_y;
  logic [2:0]             last_colour;

  logic [9:0]             px;
  logic [9:0]             py;
  logic [2:0]             pix_colour;

  // Coordinates kept 10 bits wide so that off-screen pixels never wrap back on screen.
  always_comb begin
    px = 10'(int'(form_x_r) + (int'(idx) % COLS) * STEP_X + int'(cx));
    py = 10'(int'(form_y_r) + (int'(idx) / COLS) * STEP_Y + int'(cy));
    rom_address = ROM_AW'(int'(frame_r) * (SPRITE_W * SPRITE_H) + int'(cy) * SPRITE_W + int'(cx));
  end

  // rom_q arrives in the cycle after the address, so plot is formed here from the delayed stage.
  always_comb begin
    pix_colour  = p_erase ? BG_COLOUR : rom_q;
    plot        = p_valid && (p_x < 10'(SCREEN_W)) && (p_y < 10'(SCREEN_H)) &&
                  (p_erase || (rom_q != TRANSPARENT));
    final_x_pos = plot ? p_x[8:0] : last_x;
    final_y_pos = plot ? p_y[7:0] : last_y;
    colour      = plot ? pix_colour : last_colour;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state       <= IDLE;
      idx         <= '0;
      cx          <= '0;
      cy          <= '0;
      erase_r     <= 1'b0;
      frame_r     <= '0;
      form_x_r    <= '0;
      form_y_r    <= '0;
      alive_r     <= '0;
      p_valid     <= 1'b0;
      p_erase     <= 1'b0;
      p_x         <= '0;
      p_y         <= '0;
      last_x      <= '0;
      last_y      <= '0;
      last_colour <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done    <= 1'b0;
      p_valid <= (state == DRAW);
      p_erase <= erase_r;
      p_x     <= px;
      p_y     <= py;
      if (plot) begin
        last_x      <= p_x[8:0];
        last_y      <= p_y[7:0];
        last_colour <= pix_colour;
      end
      case (state)
        IDLE: begin
          if (start) begin
            erase_r  <= erase;
            frame_r  <= frame;
            form_x_r <= form_x;
            form_y_r <= form_y;
            alive_r  <= alive;
            idx      <= '0;
            busy     <= 1'b1;
            state    <= SELECT;
          end
        end
        SELECT: begin
          if (alive_r[idx]) begin
            cx    <= '0;
            cy    <= '0;
            state <= DRAW;
          end else if (idx == IW'(NUM_ENEMIES - 1)) begin
            state <= DRAIN;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DRAW: begin
          if (cx == CXW'(SPRITE_W - 1)) begin
            cx <= '0;
            if (cy == CYW'(SPRITE_H - 1)) begin
              cy <= '0;
              if (idx == IW'(NUM_ENEMIES - 1)) begin
                state <= DRAIN;
              end else begin
                idx   <= idx + 1'b1;
                state <= SELECT;
              end
            end else begin
              cy <= cy + 1'b1;
            end
          end else begin
            cx <= cx + 1'b1;
          end
        end
        DRAIN: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_enemy_formation_drawer.sv
// Bench for enemy_formation_drawer: table of formation passes checked through a plot scoreboard,
// plus hand sequences for back-to-back starts, held start with changing inputs, and mid-pass reset.
module tb_enemy_formation_drawer;

  logic       clk;
  logic       resetn;
  logic       start;
  logic       erase;
  logic [0:0] frame;
  logic [8:0] form_x;
  logic [7:0] form_y;
  logic [7:0] alive;
  logic [7:0] rom_address;
  logic [2:0] rom_q;
  logic [8:0] final_x_pos;
  logic [7:0] final_y_pos;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  enemy_formation_drawer dut (
    .clock(clk), .resetn(resetn), .start(start), .erase(erase), .frame(frame),
    .form_x(form_x), .form_y(form_y), .alive(alive), .rom_address(rom_address),
    .rom_q(rom_q), .final_x_pos(final_x_pos), .final_y_pos(final_y_pos),
    .colour(colour), .plot(plot), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] mem [0:255];
  always @(posedge clk) rom_q <= mem[rom_address];

  typedef struct {
    int         x;
    int         y;
    logic [2:0] c;
  } pix_t;

  typedef struct {
    logic [7:0] alive;
    logic [8:0] fx;
    logic [7:0] fy;
    logic       fr;
    logic       er;
    int         pat;
    int         exp_plots;
    int         exp_lat;
  } vec_t;

  pix_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   plots;

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // pattern 0: every pixel 3'b111; pattern 1: checkerboard, opaque colour depends on frame
  task automatic load_rom(input int pat);
    for (int a = 0; a < 256; a++) begin
      logic [7:0] ab;
      ab = 8'(a);
      if (pat == 0) mem[a] = 3'b111;
      else mem[a] = (ab[0] ^ ab[4]) ? (ab[7] ? 3'b110 : 3'b011) : 3'b000;
    end
  endtask

  task automatic build_sb(input vec_t v);
    sb.delete();
    for (int e = 0; e < 8; e++) begin
      if (v.alive[e]) begin
        for (int y = 0; y < 8; y++) begin
          for (int x = 0; x < 16; x++) begin
            pix_t p;
            int   a;
            a   = int'(v.fr) * 128 + y * 16 + x;
            p.x = int'(v.fx) + (e % 4) * 20 + x;
            p.y = int'(v.fy) + (e / 4) * 12 + y;
            p.c = v.er ? 3'b000 : mem[a];
            if (p.x < 320 && p.y < 240 && (v.er || mem[a] != 3'b000)) sb.push_back(p);
          end
        end
      end
    end
  endtask

  task automatic tick();
    pix_t p;
    @(negedge clk);
    if (plot) begin
      plots++;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL plot_unexpected got=(%0d,%0d,%0d) want=none", final_x_pos, final_y_pos, colour);
      end else begin
        p = sb.pop_front();
        if (int'(final_x_pos) != p.x || int'(final_y_pos) != p.y || colour != p.c) begin
          bad++;
          $display("FAIL plot_pixel got=(%0d,%0d,%0d) want=(%0d,%0d,%0d)",
                   final_x_pos, final_y_pos, colour, p.x, p.y, p.c);
        end
      end
    end
  endtask

  task automatic run_pass(input vec_t v, input bit hold);
    int got_lat;
    int busy_cnt;
    load_rom(v.pat);
    build_sb(v);
    plots    = 0;
    busy_cnt = 0;
    got_lat  = -1;
    @(negedge clk);
    alive  = v.alive;
    form_x = v.fx;
    form_y = v.fy;
    frame  = v.fr;
    erase  = v.er;
    start  = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    for (int c = 1; c <= v.exp_lat + 40; c++) begin
      tick();
      if (busy) busy_cnt++;
      if (hold && c == 3) begin
        alive  = ~v.alive;
        form_x = v.fx + 9'd33;
        form_y = v.fy + 8'd5;
        frame  = ~v.fr;
        erase  = ~v.er;
      end
      if (done) begin
        got_lat = c;
        break;
      end
    end
    start = 1'b0;
    check("done_latency", got_lat, v.exp_lat);
    check("plot_count", plots, v.exp_plots);
    check("scoreboard_left", sb.size(), 0);
    check("busy_cycles", busy_cnt, v.exp_lat - 1);
    tick();
    check("done_one_cycle", int'(done), 0);
    check("busy_after_done", int'(busy), 0);
    sb.delete();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_plot"}, int'(plot), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_rom_address"}, int'(rom_address), 0);
    check({tag, "_x"}, int'(final_x_pos), 0);
    check({tag, "_y"}, int'(final_y_pos), 0);
    check({tag, "_colour"}, int'(colour), 0);
  endtask

  vec_t vecs [9];

  initial begin
    vec_t v;
    int   done_cnt;
    int   done_at [2];

    vecs[0] = '{8'hFF, 9'd0,   8'd0,   1'b0, 1'b0, 0, 1024, 1034};
    vecs[1] = '{8'h00, 9'd0,   8'd0,   1'b0, 1'b0, 0,    0,   10};
    vecs[2] = '{8'h01, 9'd0,   8'd0,   1'b1, 1'b0, 1,   64,  138};
    vecs[3] = '{8'h01, 9'd0,   8'd0,   1'b1, 1'b1, 1,  128,  138};
    vecs[4] = '{8'h01, 9'd310, 8'd0,   1'b0, 1'b0, 0,   80,  138};
    vecs[5] = '{8'h01, 9'd0,   8'd236, 1'b0, 1'b0, 0,   64,  138};
    vecs[6] = '{8'hA5, 9'd37,  8'd50,  1'b0, 1'b0, 1,  256,  522};
    vecs[7] = '{8'h10, 9'd0,   8'd250, 1'b0, 1'b0, 0,    0,  138};
    vecs[8] = '{8'h08, 9'd500, 8'd0,   1'b0, 1'b0, 0,    0,  138};

    resetn = 1'b0;
    start  = 1'b0;
    erase  = 1'b0;
    frame  = 1'b0;
    form_x = '0;
    form_y = '0;
    alive  = '0;
    load_rom(0);
    plots = 0;
    repeat (3) tick();
    check_zero_outputs("reset");
    resetn = 1'b1;
    tick();

    for (int n = 0; n < 9; n++) run_pass(vecs[n], 1'b0);

    // start held through the pass while every other input changes
    v = '{8'h01, 9'd40, 8'd30, 1'b0, 1'b0, 1, 64, 138};
    run_pass(v, 1'b1);
    plots = 0;
    repeat (15) tick();
    check("no_extra_pass_done", int'(done), 0);
    check("no_extra_pass_busy", int'(busy), 0);

    // start high through DONE and into the first IDLE cycle: only the IDLE one is accepted
    alive    = 8'h00;
    done_cnt = 0;
    done_at  = '{-1, -1};
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c == 11) check("idle_gap_busy", int'(busy), 0);
      if (c == 12) begin
        check("second_accept_busy", int'(busy), 1);
        start = 1'b0;
      end
      if (done) begin
        if (done_cnt < 2) done_at[done_cnt] = c;
        done_cnt++;
      end
    end
    check("b2b_done_count", done_cnt, 2);
    check("b2b_first_done", done_at[0], 10);
    check("b2b_second_done", done_at[1], 21);

    // reset in the middle of a draw pass, then a clean pass
    v = '{8'hFF, 9'd100, 8'd50, 1'b0, 1'b0, 0, 1024, 1034};
    load_rom(0);
    build_sb(v);
    @(negedge clk);
    alive  = v.alive;
    form_x = v.fx;
    form_y = v.fy;
    frame  = v.fr;
    erase  = v.er;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (300) tick();
    check("mid_pass_busy", int'(busy), 1);
    resetn = 1'b0;
    tick();
    check_zero_outputs("abort");
    resetn = 1'b1;
    sb.delete();
    done_cnt = 0;
    for (int c = 0; c < 1100; c++) begin
      tick();
      if (done) done_cnt++;
    end
    check("abort_no_done", done_cnt, 0);
    run_pass(v, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
